// File: rtl/regfile_pkg.sv
// regfile_pkg: shared clear-FSM state type and default sizing constants for the register file.
package regfile_pkg;
  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_READ_DEF = 3;
  typedef enum logic {IDLE, SWEEP} state_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with set, clear and clear-all; bit 0 never set.
module regfile_scoreboard #(
  parameter  int NUM_REGS = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                set_i,
  input  logic [AW-1:0]       set_idx_i,
  input  logic                clr_i,
  input  logic [AW-1:0]       clr_idx_i,
  input  logic                clr_all_i,
  output logic [NUM_REGS-1:0] busy_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  // set is applied after clear so a same-index reserve overrides the write's clear
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_idx_i] = 1'b0;
    if (set_i) busy_d[set_idx_i] = 1'b1;
    if (clr_all_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  assign busy_o = busy_q;
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: multi-read-port register file with write bypass, busy scoreboard and clear sweep.
// Optional REGFILE_TRACE_EN prints a trace line for each accepted write and sweep start/end.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int NUM_READ = NUM_READ_DEF,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     in_write_enable,
  input  logic [AW-1:0]            in_write_register_select,
  input  logic [XLEN-1:0]          in_write_data,
  input  logic [NUM_READ*AW-1:0]   in_read_register_select,
  output logic [NUM_READ*XLEN-1:0] out_read_data,
  output logic [NUM_READ-1:0]      out_read_busy,
  input  logic                     in_reserve_enable,
  input  logic [AW-1:0]            in_reserve_register_select,
  input  logic                     in_clear_req,
  output logic                     out_clear_busy
);
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
  state_t            state_q, state_d;
  logic [AW-1:0]     sweep_idx_q, sweep_idx_d;
  logic [XLEN-1:0]   bank_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic idle, start, wr_acc, rsv_acc;
  assign idle    = state_q == IDLE;
  assign start   = idle && in_clear_req;
  assign wr_acc  = RESET_N && idle && !in_clear_req && in_write_enable && in_write_register_select != '0;
  assign rsv_acc = idle && !in_clear_req && in_reserve_enable && in_reserve_register_select != '0;
  assign out_clear_busy = !idle;
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    if (start) state_d = SWEEP;
    else if (!idle) begin
      state_d     = sweep_idx_q == LAST ? IDLE : SWEEP;
      sweep_idx_d = sweep_idx_q == LAST ? AW'(1) : sweep_idx_q + AW'(1);
    end
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q     <= IDLE;
      sweep_idx_q <= AW'(1);
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      if (!idle)       bank_q[sweep_idx_q] <= '0;
      else if (wr_acc) bank_q[in_write_register_select] <= in_write_data;
    end
  regfile_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk_i    (CLK),
    .rst_ni   (RESET_N),
    .set_i    (rsv_acc),
    .set_idx_i(in_reserve_register_select),
    .clr_i    (wr_acc),
    .clr_idx_i(in_write_register_select),
    .clr_all_i(start),
    .busy_o   (busy)
  );
  // busy is deliberately not bypassed: it reflects the registered scoreboard only
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [AW-1:0] sel;
    assign sel = in_read_register_select[p*AW +: AW];
    assign out_read_data[p*XLEN +: XLEN] =
      (wr_acc && sel == in_write_register_select) ? in_write_data : bank_q[sel];
    assign out_read_busy[p] = busy[sel];
  end
`ifdef REGFILE_TRACE_EN
  always_ff @(posedge CLK)
    if (RESET_N) begin
      if (wr_acc) $display("regfile: write r%0d = %h", in_write_register_select, in_write_data);
      if (start) $display("regfile: sweep start");
      if (!idle && sweep_idx_q == LAST) $display("regfile: sweep end r%0d = 0", sweep_idx_q);
    end
`endif
endmodule
